// File: rtl/edge_prescaler.sv
// Edge prescaler: counts rising edges of a sampled input and emits a tick
// plus a 50%-duty toggle every div+1 counted edges.
module edge_prescaler #(
   parameter int WIDTH   = 8,
   parameter int DIV_RST = 1,
   parameter bit SYNC_EN = 1'b0
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             en_i,
   input  logic             in_i,
   input  logic             load_i,
   input  logic [WIDTH-1:0] div_i,
   output logic             tick_o,
   output logic             tgl_o,
   output logic [WIDTH-1:0] cnt_o
);

   localparam logic [WIDTH-1:0] DIV_INIT = WIDTH'(DIV_RST);

   logic             s;
   logic             s_r;
   logic             rise;
   logic             hit;
   logic [WIDTH-1:0] div_r;
   logic [WIDTH-1:0] cnt;
   logic             tick;
   logic             tgl;

   // Input sampling: either a two-flop synchroniser or a direct tap.
   generate
      if (SYNC_EN) begin : g_sync
         logic sync_p0;
         logic sync_p1;

         always_ff @(posedge clk_i) begin
            if (rst_i) begin
               sync_p0 <= 1'b0;
               sync_p1 <= 1'b0;
            end else begin
               sync_p0 <= in_i;
               sync_p1 <= sync_p0;
            end
         end

         assign s = sync_p1;
      end else begin : g_direct
         assign s = in_i;
      end
   endgenerate

   assign rise = s & ~s_r;

   // Using >= rather than == lets any stale count above the divisor wrap on
   // the next counted edge, so the counter can never run past all-ones.
   assign hit = (cnt >= div_r);

   // Edge history, divisor, counter and outputs.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         s_r   <= 1'b0;
         div_r <= DIV_INIT;
         cnt   <= '0;
         tick  <= 1'b0;
         tgl   <= 1'b0;
      end else begin
         // s_r tracks s even while disabled so raising en_i never fakes an edge.
         s_r  <= s;
         tick <= 1'b0;
         if (load_i) begin
            div_r <= div_i;
            cnt   <= '0;
         end else if (en_i && rise) begin
            if (hit) begin
               cnt  <= '0;
               tick <= 1'b1;
               tgl  <= ~tgl;
            end else begin
               cnt <= cnt + WIDTH'(1);
            end
         end
      end
   end

   assign tick_o = tick;
   assign tgl_o  = tgl;
   assign cnt_o  = cnt;

endmodule

// File: tb/tb_edge_prescaler.sv
// Bench for edge_prescaler: directed vector table, corner sequences and a
// randomized run against an edge-count reference model.
module tb_edge_prescaler;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       en = 1'b0;
   logic       load = 1'b0;
   logic       in_sig = 1'b0;
   logic [7:0] div = 8'd0;

   logic       tick0, tgl0, tick1, tgl1;
   logic [7:0] cnt0, cnt1;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   edge_prescaler #(.WIDTH(8), .DIV_RST(1), .SYNC_EN(1'b0)) dut0 (
      .clk_i(clk), .rst_i(rst), .en_i(en), .in_i(in_sig), .load_i(load),
      .div_i(div), .tick_o(tick0), .tgl_o(tgl0), .cnt_o(cnt0)
   );

   edge_prescaler #(.WIDTH(8), .DIV_RST(1), .SYNC_EN(1'b1)) dut1 (
      .clk_i(clk), .rst_i(rst), .en_i(en), .in_i(in_sig), .load_i(load),
      .div_i(div), .tick_o(tick1), .tgl_o(tgl1), .cnt_o(cnt1)
   );

   // Reference model: number of counted edges since the last load/reset,
   // with the count reported modulo (div+1) and the toggle as tick parity.
   int m_n   [2];
   int m_div [2];
   bit m_tick[2];
   bit m_tgl [2];
   bit m_hist[2][4];

   function automatic int m_cnt(int m);
      return m_n[m] % (m_div[m] + 1);
   endfunction

   task automatic model_step();
      for (int m = 0; m < 2; m++) begin
         int  lag;
         bit  e;
         lag = (m == 0) ? 0 : 2;
         if (rst) begin
            for (int i = 0; i < 4; i++) m_hist[m][i] = 1'b0;
            m_n[m]    = 0;
            m_div[m]  = 1;
            m_tick[m] = 1'b0;
            m_tgl[m]  = 1'b0;
         end else begin
            for (int i = 3; i > 0; i--) m_hist[m][i] = m_hist[m][i-1];
            m_hist[m][0] = in_sig;
            e = m_hist[m][lag] && !m_hist[m][lag+1];
            m_tick[m] = 1'b0;
            if (load) begin
               m_div[m] = int'(div);
               m_n[m]   = 0;
            end else if (en && e) begin
               m_n[m]++;
               if (m_n[m] % (m_div[m] + 1) == 0) begin
                  m_tick[m] = 1'b1;
                  m_tgl[m]  = ~m_tgl[m];
               end
            end
         end
      end
   endtask

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // Drive one cycle of inputs, advance the model and compare both DUTs.
   task automatic cyc(input bit r, input bit e, input bit l, input logic [7:0] d, input bit i);
      rst = r; en = e; load = l; div = d; in_sig = i;
      @(posedge clk);
      model_step();
      @(negedge clk);
      chk("tick0_model", int'(tick0), int'(m_tick[0]));
      chk("cnt0_model",  int'(cnt0),  m_cnt(0));
      chk("tgl0_model",  int'(tgl0),  int'(m_tgl[0]));
      chk("tick1_model", int'(tick1), int'(m_tick[1]));
      chk("cnt1_model",  int'(cnt1),  m_cnt(1));
      chk("tgl1_model",  int'(tgl1),  int'(m_tgl[1]));
   endtask

   typedef struct {
      bit         r, e, l;
      logic [7:0] d;
      bit         i;
      bit         tk;
      logic [7:0] cn;
      bit         tg;
   } vec_t;

   function automatic vec_t mk(bit r, bit e, bit l, logic [7:0] d, bit i,
                               bit tk, logic [7:0] cn, bit tg);
      vec_t v;
      v.r = r; v.e = e; v.l = l; v.d = d; v.i = i;
      v.tk = tk; v.cn = cn; v.tg = tg;
      return v;
   endfunction

   vec_t tbl[$];

   initial begin
      int ticks;
      int toggles;
      bit last_tgl;

      // Directed vectors for the direct-sampled instance (DIV_RST=1).
      tbl.push_back(mk(1,0,0,0,0, 0,0,0));
      tbl.push_back(mk(0,1,0,0,1, 0,1,0));
      tbl.push_back(mk(0,1,0,0,0, 0,1,0));
      tbl.push_back(mk(0,1,0,0,1, 1,0,1));
      tbl.push_back(mk(0,1,0,0,0, 0,0,1));
      tbl.push_back(mk(0,1,1,4,1, 0,0,1));
      tbl.push_back(mk(0,1,0,0,0, 0,0,1));
      tbl.push_back(mk(0,1,0,0,1, 0,1,1));
      tbl.push_back(mk(0,1,0,0,0, 0,1,1));
      tbl.push_back(mk(0,1,0,0,1, 0,2,1));
      tbl.push_back(mk(0,1,0,0,0, 0,2,1));
      tbl.push_back(mk(0,1,0,0,1, 0,3,1));
      tbl.push_back(mk(0,1,0,0,0, 0,3,1));
      tbl.push_back(mk(0,1,0,0,1, 0,4,1));
      tbl.push_back(mk(0,1,0,0,0, 0,4,1));
      tbl.push_back(mk(0,1,0,0,1, 1,0,0));
      tbl.push_back(mk(0,1,0,0,0, 0,0,0));
      tbl.push_back(mk(0,0,0,0,1, 0,0,0));
      tbl.push_back(mk(0,1,0,0,1, 0,0,0));
      tbl.push_back(mk(0,1,0,0,0, 0,0,0));
      tbl.push_back(mk(0,1,0,0,1, 0,1,0));
      tbl.push_back(mk(0,1,1,0,0, 0,0,0));
      tbl.push_back(mk(0,1,0,0,1, 1,0,1));
      tbl.push_back(mk(0,1,0,0,0, 0,0,1));
      tbl.push_back(mk(0,1,0,0,1, 1,0,0));
      tbl.push_back(mk(1,0,0,0,0, 0,0,0));
      tbl.push_back(mk(0,1,0,0,1, 0,1,0));
      tbl.push_back(mk(0,1,0,0,0, 0,1,0));
      tbl.push_back(mk(0,1,1,3,1, 0,0,0));
      tbl.push_back(mk(0,1,0,0,0, 0,0,0));
      tbl.push_back(mk(0,1,0,0,1, 0,1,0));
      tbl.push_back(mk(0,1,0,0,0, 0,1,0));
      tbl.push_back(mk(0,1,0,0,1, 0,2,0));
      tbl.push_back(mk(0,1,0,0,0, 0,2,0));
      tbl.push_back(mk(0,1,0,0,1, 0,3,0));
      tbl.push_back(mk(0,1,0,0,0, 0,3,0));
      tbl.push_back(mk(1,1,0,0,1, 0,0,0));
      tbl.push_back(mk(0,1,0,0,1, 0,1,0));
      tbl.push_back(mk(0,1,0,0,0, 0,1,0));
      tbl.push_back(mk(0,1,0,0,1, 1,0,1));

      foreach (tbl[k]) begin
         cyc(tbl[k].r, tbl[k].e, tbl[k].l, tbl[k].d, tbl[k].i);
         chk($sformatf("vec%0d_tick", k), int'(tick0), int'(tbl[k].tk));
         chk($sformatf("vec%0d_cnt", k),  int'(cnt0),  int'(tbl[k].cn));
         chk($sformatf("vec%0d_tgl", k),  int'(tgl0),  int'(tbl[k].tg));
      end

      // Square wave of period 4 at reset divisor: tick every 2nd rise.
      cyc(1,0,0,0,0);
      ticks = 0; toggles = 0; last_tgl = tgl0;
      for (int c = 0; c < 32; c++) begin
         cyc(0,1,0,0,(c % 4) < 2);
         if (tick0) ticks++;
         if (tgl0 != last_tgl) toggles++;
         last_tgl = tgl0;
      end
      chk("sq_ticks", ticks, 4);
      chk("sq_toggles", toggles, 4);

      // Synchronised instance with divide-by-1: tick three cycles after the rise.
      cyc(1,0,0,0,0);
      cyc(0,1,1,0,0);
      cyc(0,1,0,0,0);
      cyc(0,1,0,0,1);
      chk("sync_lat1_tick", int'(tick1), 0);
      cyc(0,1,0,0,1);
      chk("sync_lat2_tick", int'(tick1), 0);
      cyc(0,1,0,0,1);
      chk("sync_lat3_tick", int'(tick1), 1);
      chk("sync_lat3_cnt",  int'(cnt1), 0);
      cyc(0,1,0,0,1);
      chk("sync_hold_tick", int'(tick1), 0);

      // Enable low across three edges, then enable rises with input held high.
      cyc(1,0,0,0,0);
      cyc(0,1,0,0,1);
      cyc(0,1,0,0,0);
      for (int c = 0; c < 3; c++) begin
         cyc(0,0,0,0,1);
         cyc(0,0,0,0,0);
      end
      cyc(0,0,0,0,1);
      cyc(0,1,0,0,1);
      cyc(0,1,0,0,1);
      chk("en_rise_cnt", int'(cnt0), 1);
      chk("en_rise_tick", int'(tick0), 0);

      // All-ones divisor: 256 edges per tick.
      cyc(1,0,0,0,0);
      cyc(0,1,1,8'hFF,0);
      ticks = 0;
      for (int c = 0; c < 255; c++) begin
         cyc(0,1,0,0,1);
         if (tick0) ticks++;
         cyc(0,1,0,0,0);
      end
      chk("div255_pre_cnt", int'(cnt0), 255);
      chk("div255_pre_ticks", ticks, 0);
      cyc(0,1,0,0,1);
      chk("div255_wrap_tick", int'(tick0), 1);
      chk("div255_wrap_cnt",  int'(cnt0), 0);

      // Randomized traffic against the model.
      cyc(1,0,0,0,0);
      for (int c = 0; c < 3000; c++) begin
         bit         r, e, l, i;
         logic [7:0] d;
         r = ($urandom_range(0, 99) < 2);
         e = ($urandom_range(0, 3) != 0);
         l = ($urandom_range(0, 19) == 0);
         d = ($urandom_range(0, 9) == 0) ? 8'($urandom_range(0, 255))
                                          : 8'($urandom_range(0, 5));
         i = 1'($urandom_range(0, 1));
         cyc(r, e, l, d, i);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/edge_prescaler.md
EDGE_PRESCALER -- requirements
Module: edge_prescaler

Interface
REQ-001 Parameter WIDTH, default 8: width of the divide register and the edge counter, legal range 1 to 16.
REQ-002 Parameter DIV_RST, default 1: divide value loaded at reset; it SHALL fit in WIDTH bits.
REQ-003 Parameter SYNC_EN, default 0: 1 inserts a 2-flop synchroniser on in_i; 0 samples in_i directly.
REQ-004 clk_i  input  1  single clock; all logic SHALL be clocked on its rising edge.
REQ-005 rst_i  input  1  reset, synchronous and active-high.
REQ-006 en_i  input  1  count enable; edges are counted only while high.
REQ-007 in_i  input  1  signal whose rising edges are counted, sampled on clk_i.
REQ-008 load_i  input  1  single-cycle strobe that captures div_i and clears the count.
REQ-009 div_i  input  WIDTH  new divide value, meaning divide by div_i+1.
REQ-010 tick_o  output  1  one-cycle pulse on each terminal count.
REQ-011 tgl_o  output  1  toggles on each terminal count, giving a 50%-duty output at in_i/(2*(div+1)).
REQ-012 cnt_o  output  WIDTH  current edge count.

Function
REQ-013 The block SHALL define the sampled input s as in_i when SYNC_EN=0, and as the second synchroniser flop when SYNC_EN=1.
REQ-014 A register s_r SHALL hold s delayed by one cycle, and edge = s & ~s_r.
REQ-015 s_r SHALL update every cycle regardless of en_i, so that raising en_i never creates a false edge.
REQ-016 The block SHALL hold div_r (WIDTH bits); load_i=1 SHALL set div_r<=div_i and cnt<=0 in the same cycle.
REQ-017 When load_i=0 and en_i=1 and edge=1: if cnt==div_r, cnt<=0, tick_o<=1 and tgl_o<=~tgl_o; otherwise cnt<=cnt+1 and tick_o<=0.
REQ-018 In every other cycle, tick_o SHALL be 0 and cnt and tgl_o SHALL hold.
REQ-019 tick_o SHALL be registered, high for exactly one cycle, in the cycle following the clock edge at which edge=1 was seen.
REQ-020 Latency from in_i rising to tick_o high SHALL be 1 cycle for SYNC_EN=0 and 3 cycles for SYNC_EN=1.
REQ-021 If load_i and edge occur in the same cycle, the load SHALL win: the edge is discarded, tick_o=0 and tgl_o holds.
REQ-022 div_r=0 SHALL mean divide by 1: every counted edge ticks and cnt_o stays 0.
REQ-023 If cnt>div_r (only possible transiently), the next counted edge SHALL wrap cnt to 0 with a tick, and the counter SHALL never run past all-ones.
REQ-024 If div_r is all-ones, cnt SHALL wrap from all-ones to 0 with a tick, so the division is 2^WIDTH.
REQ-025 cnt_o SHALL equal cnt directly, with no extra delay.
REQ-026 en_i=0 SHALL freeze cnt and tgl_o, but load_i SHALL still act.

Reset
REQ-027 rst_i=1 at a clock edge SHALL set cnt=0, tick_o=0, tgl_o=0, s_r=0, synchroniser flops=0 and div_r=DIV_RST.
REQ-028 Reset SHALL take priority over load_i, en_i and edge.
REQ-029 Reset asserted mid-count SHALL abandon the count, with no tick emitted in the following cycle.
REQ-030 After reset releases, in_i held high SHALL produce one edge only if s_r was 0, which is always the case after reset.

Verification
REQ-031 WIDTH=8, DIV_RST=1, SYNC_EN=0, en_i=1, in_i as a square wave of 4-cycle period -> tick_o pulses on every 2nd in_i rise, 1 cycle after the rise; tgl_o period 16 cycles.
REQ-032 load_i with div_i=4, then 10 edges -> cnt_o steps 0,1,2,3,4,0,...; tick_o asserted exactly 2 times.
REQ-033 load_i coincident with an edge when cnt=div_r=1 -> tick_o stays 0, cnt_o=0 and div_r takes the new value.
REQ-034 en_i low across 3 edges, then in_i held high while en_i rises -> cnt_o unchanged and no edge counted on en_i rise.
REQ-035 div_i=0 loaded, SYNC_EN=1 -> tick_o on every edge, 3 cycles after each in_i rise, with cnt_o constantly 0.
REQ-036 rst_i pulsed when cnt=div_r with an edge pending -> tick_o=0 next cycle, all outputs 0 and div_r=DIV_RST.
